out_channel_reader: RTL and testbench
=====================================

Name: out_channel_reader

Overview:
- Receiving end of the program out channel.
- The test program's out instruction pushes one word per step. This block captures each word into a circular buffer of NOut entries and streams the words to a host, oldest first, over a valid/ready handshake.
- It tracks overflow when the program outruns the host.
- It raises drained once the program has finished and every captured word has been delivered.

Parameters:
- MemoryElementWidth, 12, width of one channel word.
- NOut, 100, number of buffer entries; must be at least 2.
- PtrWidth, $clog2(NOut), width of the read and write positions.
- CountWidth, $clog2(NOut+1), width of the occupancy count.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- out_valid  in  1  program executed an out instruction this cycle.
- out_data  in  MemoryElementWidth  word written by that out instruction.
- finished  in  1  program finished; level, sampled each cycle.
- rd_valid  out  1  rd_data holds the oldest undelivered word.
- rd_ready  in  1  host accepts rd_data this cycle.
- rd_data  out  MemoryElementWidth  oldest undelivered word.
- count  out  CountWidth  number of undelivered words.
- overflow  out  1  sticky; set when an unread word has been overwritten.
- dropped  out  MemoryElementWidth  number of overwritten words; saturates at all-ones.
- drained  out  1  program finished and buffer empty.

Behaviour:
- Reset: when reset==0 at a posedge, all of the following clear:
  - outputs rd_valid, rd_data, count, overflow, dropped, drained;
  - internal read and write positions;
  - state, which returns to RUN.
- Reset mid-operation discards all buffered words. Buffer RAM contents need not clear.
- Write side never stalls; the program is not back-pressured.
  - A write stores out_data at wrPos, then wrPos=(wrPos+1)%NOut. The wrap is explicit; do not rely on power-of-two wrap.
- Read side: rd_valid = (count!=0). rd_data is the buffer entry at rdPos.
  - rd_data is registered, so a word written at cycle N is visible on rd_data/rd_valid at cycle N+1. There is no same-cycle bypass.
  - A handshake completes when rd_valid && rd_ready; rdPos then advances modulo NOut and count decrements.
  - rd_data must stay stable while rd_valid && !rd_ready.
- Full (count==NOut), write with no completed read: the oldest word is overwritten.
  - rdPos advances, count is unchanged, overflow is set to 1 and stays set, and dropped increments by 1 (saturating).
- Full, write and completed read in the same cycle: the read delivers the oldest word and the write takes its slot. No overflow, count unchanged.
- Empty (count==0): rd_ready is ignored. A write makes count=1.
- Not full, write and read in the same cycle: count unchanged, both pointers advance.
- State machine:
  - RUN: writes accepted. When finished==1, go to DRAIN.
  - DRAIN: out_valid ignored, since no further program output is defined after finished; reads continue. When count==0 and no write is pending, go to DONE.
  - DONE: drained=1, reads of an empty buffer are ignored, out_valid ignored. Leave only via reset.
- A write in the same cycle that finished first rises is accepted; it is the program's last out instruction.
- drained is registered and rises one cycle after the cycle in which DRAIN observes count==0.
- count, overflow and dropped are registered, updated at the same edge as the pointers.

Test Plan:
- Basic: reset 0 then 1; one write of 2; rd_ready=1 -> next cycle rd_valid=1, rd_data=2; count 1->0 after the handshake; overflow=0.
- Stall: write 5, 7, 9 with rd_ready=0 -> count=3, rd_data holds 5. Then rd_ready=1 for 3 cycles -> 5, 7, 9 delivered in order, count=0.
- Wrap and overflow: NOut=4, write 1..6 with rd_ready=0 -> count=4, dropped=2, overflow=1; reads return 3, 4, 5, 6.
- Full simultaneous: NOut=4, full with 1..4; write 10 with rd_ready=1 in the same cycle -> 1 delivered, count=4, overflow=0; subsequent reads 2, 3, 4, 10.
- Drain: write 2, assert finished with rd_ready=0 for 3 cycles -> drained=0. Raise rd_ready -> 2 delivered, drained=1 one cycle later. A later out_valid with 8 is ignored and count stays 0.
- Reset mid-operation: 3 words buffered with overflow=1; pulse reset low for one cycle -> count=0, rd_valid=0, overflow=0, dropped=0, drained=0. A new write of 4 is then delivered as 4.

Source files
------------

// File: rtl/out_channel_reader.sv
// Receiving end of the program out channel: circular capture buffer streamed to a
// host over valid/ready, with overflow tracking and end-of-program drain detection.
module out_channel_reader #(
   parameter int unsigned MemoryElementWidth = 12,
   parameter int unsigned NOut               = 100,
   parameter int unsigned PtrWidth           = $clog2(NOut),
   parameter int unsigned CountWidth         = $clog2(NOut + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          out_valid,
   input  logic [MemoryElementWidth-1:0] out_data,
   input  logic                          finished,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [MemoryElementWidth-1:0] rd_data,
   output logic [CountWidth-1:0]         count,
   output logic                          overflow,
   output logic [MemoryElementWidth-1:0] dropped,
   output logic                          drained
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e                          state_q, state_d;
   logic [PtrWidth-1:0]             wr_pos_q, wr_pos_d;
   logic [PtrWidth-1:0]             rd_pos_q, rd_pos_d;
   logic [CountWidth-1:0]           count_q, count_d;
   logic                            overflow_q, overflow_d;
   logic [MemoryElementWidth-1:0]   dropped_q, dropped_d;
   logic [MemoryElementWidth-1:0]   rd_data_q, rd_data_d;
   logic                            rd_valid_q, rd_valid_d;
   logic                            drained_q, drained_d;
   logic [MemoryElementWidth-1:0]   mem_q [NOut];

   logic wr_en_c;
   logic rd_fire_c;
   logic full_c;
   logic overwrite_c;

   // Explicit modulo-NOut increment; NOut need not be a power of two.
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(NOut - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      wr_pos_d    = wr_pos_q;
      rd_pos_d    = rd_pos_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      dropped_d   = dropped_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      drained_d   = drained_q;

      wr_en_c     = out_valid && (state_q == ST_RUN);
      rd_fire_c   = rd_valid_q && rd_ready;
      full_c      = (count_q == CountWidth'(NOut));
      overwrite_c = wr_en_c && full_c && !rd_fire_c;

      if (wr_en_c) begin
         wr_pos_d = ptr_inc(wr_pos_q);
      end
      if (rd_fire_c || overwrite_c) begin
         rd_pos_d = ptr_inc(rd_pos_q);
      end

      if (wr_en_c && !rd_fire_c && !full_c) begin
         count_d = count_q + CountWidth'(1);
      end else if (rd_fire_c && !wr_en_c) begin
         count_d = count_q - CountWidth'(1);
      end

      if (overwrite_c) begin
         overflow_d = 1'b1;
         if (dropped_q != '1) begin
            dropped_d = dropped_q + MemoryElementWidth'(1);
         end
      end

      // Head word after this edge; a write landing on the new head bypasses the array.
      if (wr_en_c && (wr_pos_q == rd_pos_d)) begin
         rd_data_d = out_data;
      end else begin
         rd_data_d = mem_q[rd_pos_d];
      end
      rd_valid_d = (count_d != '0);

      unique case (state_q)
         ST_RUN:   if (finished) state_d = ST_DRAIN;
         ST_DRAIN: if (count_q == '0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_RUN;
      endcase
      drained_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         wr_pos_q   <= '0;
         rd_pos_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         drained_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_pos_q   <= wr_pos_d;
         rd_pos_q   <= rd_pos_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         drained_q  <= drained_d;
      end
   end

   // Buffer storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (reset && wr_en_c) begin
         mem_q[wr_pos_q] <= out_data;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign dropped  = dropped_q;
   assign drained  = drained_q;

endmodule

// File: tb/tb_out_channel_reader.sv
// Bench for out_channel_reader: directed vector table on a 4-entry instance, then
// random traffic on 4- and 5-entry instances against a queue-based reference model.
module tb_out_channel_reader;

   localparam int unsigned W = 12;

   logic          clock = 1'b0;
   logic          reset;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          finished;
   logic          rd_ready;

   logic          rv4, ovf4, drn4;
   logic [W-1:0]  rdat4, drop4;
   logic [2:0]    cnt4;
   logic          rv5, ovf5, drn5;
   logic [W-1:0]  rdat5, drop5;
   logic [2:0]    cnt5;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   out_channel_reader #(.MemoryElementWidth(W), .NOut(4)) dut4 (
      .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
      .finished(finished), .rd_valid(rv4), .rd_ready(rd_ready), .rd_data(rdat4),
      .count(cnt4), .overflow(ovf4), .dropped(drop4), .drained(drn4));

   out_channel_reader #(.MemoryElementWidth(W), .NOut(5)) dut5 (
      .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
      .finished(finished), .rd_valid(rv5), .rd_ready(rd_ready), .rd_data(rdat5),
      .count(cnt5), .overflow(ovf5), .dropped(drop5), .drained(drn5));

   // Reference model: a FIFO of undelivered words plus a few flags per instance.
   logic [W-1:0] mq [2][$];
   bit           m_ovf  [2];
   int           m_drop [2];
   bit           m_fin  [2];
   bit           m_done [2];
   bit           m_rst  [2];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input int k, input int n);
      int old_sz;
      if (!reset) begin
         mq[k].delete();
         m_ovf[k] = 0; m_drop[k] = 0; m_fin[k] = 0; m_done[k] = 0; m_rst[k] = 1;
         return;
      end
      m_rst[k] = 0;
      old_sz = mq[k].size();
      if (old_sz > 0 && rd_ready) void'(mq[k].pop_front());
      if (out_valid && !m_fin[k]) begin
         if (mq[k].size() == n) begin
            void'(mq[k].pop_front());
            m_ovf[k] = 1;
            if (m_drop[k] < 4095) m_drop[k]++;
         end
         mq[k].push_back(out_data);
      end
      if (m_fin[k] && !m_done[k] && old_sz == 0) m_done[k] = 1;
      if (finished) m_fin[k] = 1;
   endtask

   task automatic model_cmp(input int k, input string tag, input logic rv, input logic [W-1:0] rdat,
                            input logic [2:0] cnt, input logic ovf, input logic [W-1:0] drop,
                            input logic drn);
      check({tag, ".count"},    int'(cnt),  mq[k].size());
      check({tag, ".rd_valid"}, int'(rv),   int'(mq[k].size() > 0));
      check({tag, ".overflow"}, int'(ovf),  int'(m_ovf[k]));
      check({tag, ".dropped"},  int'(drop), m_drop[k]);
      check({tag, ".drained"},  int'(drn),  int'(m_done[k]));
      if (mq[k].size() > 0) check({tag, ".rd_data"}, int'(rdat), int'(mq[k][0]));
      else if (m_rst[k])    check({tag, ".rd_data_rst"}, int'(rdat), 0);
   endtask

   // One clock: inputs already driven, advance the model on the edge, compare after it.
   task automatic step();
      @(posedge clock);
      model_step(0, 4);
      model_step(1, 5);
      #1;
      model_cmp(0, "m4", rv4, rdat4, cnt4, ovf4, drop4, drn4);
      model_cmp(1, "m5", rv5, rdat5, cnt5, ovf5, drop5, drn5);
   endtask

   typedef struct {
      bit rst; bit ov; int od; bit fin; bit rdy;
      int cnt; bit v; bit chk; int dat; bit ovf; int drop; bit drn;
   } vec_t;

   function automatic vec_t mk(bit rst, bit ov, int od, bit fin, bit rdy,
                               int cnt, bit v, bit chk, int dat, bit ovf, int drop, bit drn);
      vec_t r;
      r.rst = rst; r.ov = ov; r.od = od; r.fin = fin; r.rdy = rdy;
      r.cnt = cnt; r.v = v; r.chk = chk; r.dat = dat; r.ovf = ovf; r.drop = drop; r.drn = drn;
      return r;
   endfunction

   vec_t tbl[$];
   bit   fin_lvl;

   initial begin
      reset = 1'b0; out_valid = 1'b0; out_data = '0; finished = 1'b0; rd_ready = 1'b0;

      // Basic
      tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0));
      tbl.push_back(mk(1,1,2,0,1, 1,1,1,2,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,0));
      // Stall then in-order delivery
      tbl.push_back(mk(1,1,5,0,0, 1,1,1,5,0,0,0));
      tbl.push_back(mk(1,1,7,0,0, 2,1,1,5,0,0,0));
      tbl.push_back(mk(1,1,9,0,0, 3,1,1,5,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 2,1,1,7,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 1,1,1,9,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,0));
      // Wrap and overflow
      for (int i = 1; i <= 4; i++) tbl.push_back(mk(1,1,i,0,0, i,1,1,1,0,0,0));
      tbl.push_back(mk(1,1,5,0,0, 4,1,1,2,1,1,0));
      tbl.push_back(mk(1,1,6,0,0, 4,1,1,3,1,2,0));
      tbl.push_back(mk(1,0,0,0,1, 3,1,1,4,1,2,0));
      tbl.push_back(mk(1,0,0,0,1, 2,1,1,5,1,2,0));
      tbl.push_back(mk(1,0,0,0,1, 1,1,1,6,1,2,0));
      tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,1,2,0));
      // Full with simultaneous write and read
      tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0));
      for (int i = 1; i <= 4; i++) tbl.push_back(mk(1,1,i,0,0, i,1,1,1,0,0,0));
      tbl.push_back(mk(1,1,10,0,1, 4,1,1,2,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 3,1,1,3,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 2,1,1,4,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 1,1,1,10,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,0));
      // Drain
      tbl.push_back(mk(1,1,2,0,0, 1,1,1,2,0,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,1,0, 1,1,1,2,0,0,0));
      tbl.push_back(mk(1,0,0,1,1, 0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,1,0, 0,0,0,0,0,0,1));
      tbl.push_back(mk(1,1,8,0,1, 0,0,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,1));
      // Reset mid-operation
      tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0));
      for (int i = 1; i <= 4; i++) tbl.push_back(mk(1,1,i,0,0, i,1,1,1,0,0,0));
      tbl.push_back(mk(1,1,5,0,0, 4,1,1,2,1,1,0));
      tbl.push_back(mk(1,0,0,0,1, 3,1,1,3,1,1,0));
      tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0));
      tbl.push_back(mk(1,1,4,0,0, 1,1,1,4,0,0,0));
      tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,0));

      #2;
      foreach (tbl[i]) begin
         reset     = tbl[i].rst;
         out_valid = tbl[i].ov;
         out_data  = W'(tbl[i].od);
         finished  = tbl[i].fin;
         rd_ready  = tbl[i].rdy;
         step();
         check($sformatf("v%0d.count", i),    int'(cnt4),  tbl[i].cnt);
         check($sformatf("v%0d.rd_valid", i), int'(rv4),   int'(tbl[i].v));
         check($sformatf("v%0d.overflow", i), int'(ovf4),  int'(tbl[i].ovf));
         check($sformatf("v%0d.dropped", i),  int'(drop4), tbl[i].drop);
         check($sformatf("v%0d.drained", i),  int'(drn4),  int'(tbl[i].drn));
         if (tbl[i].chk) check($sformatf("v%0d.rd_data", i), int'(rdat4), tbl[i].dat);
      end

      // Random traffic; finished is a level held until the next reset.
      fin_lvl = 0;
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 149) != 0);
         if (!reset) fin_lvl = 0;
         else if (!fin_lvl && $urandom_range(0, 59) == 0) fin_lvl = 1;
         finished  = fin_lvl;
         out_valid = $urandom_range(0, 1) == 1;
         out_data  = W'($urandom);
         rd_ready  = $urandom_range(0, 9) < 4;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
